arith_accumulator: RTL and testbench

//  Downstream of arithmetic_unit; consumes its 32-bit packed product word p each valid cycle.

---
 rtl/arith_accumulator.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_arith_accumulator.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_accumulator.sv
// rtl/arith_accumulator.sv - per-lane dot-product accumulator feeding a result FIFO
//
// Sums the packed products of arithmetic_unit lane by lane over one group
// (closed by p_last) and queues each group result for writeback.
//
// Optional build macro: ACC_SAT_EN
//   defined   : lane adds saturate, sat_flag[3:0] reports per-lane saturation per result
//   undefined : lane adds wrap modulo 2^ACC_W, no sat_flag port
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   p            packed product word (mode 0: 2x16b, mode 1: 4x8b)
//   p_valid      p valid this cycle (never back-pressured)
//   p_last       final beat of the current group
//   mode         lane format of p
//   acc_out      FIFO head result, lane k at [k*ACC_W +: ACC_W]; 0 when empty
//   acc_mode     lane format of the head result
//   out_valid    FIFO head valid
//   out_ready    consumer accepts head
//   almost_full  fifo count >= max(OUT_DEPTH-SLACK, 1)
//   ovf_err      sticky: a group result was dropped on a full FIFO
//   mode_err     sticky: mode changed inside a group
//   sat_flag     (ACC_SAT_EN only) per-lane saturation of the head result
//   clr_err      synchronous clear of both sticky errors
module arith_accumulator #(
    parameter int ACC_W     = 24,
    parameter int OUT_DEPTH = 4,
    parameter int SLACK     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          p,
    input  logic                 p_valid,
    input  logic                 p_last,
    input  logic                 mode,
    output logic [4*ACC_W-1:0]   acc_out,
    output logic                 acc_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 almost_full,
    output logic                 ovf_err,
    output logic                 mode_err,
`ifdef ACC_SAT_EN
    output logic [3:0]           sat_flag,
`endif
    input  logic                 clr_err
);

    localparam int PW     = $clog2(OUT_DEPTH);
    localparam int CW     = PW + 1;
    localparam int AF_RAW = OUT_DEPTH - SLACK;
    localparam int AF_TH  = (AF_RAW < 1) ? 1 : AF_RAW;
    localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_TH);

`ifdef ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                   state_q, state_d;
    logic                     grp_mode_q, grp_mode_d;
    logic signed [ACC_W-1:0]  acc_q [4];
    logic signed [ACC_W-1:0]  acc_d [4];
    logic                     ovf_err_q, ovf_err_d;
    logic                     mode_err_q, mode_err_d;

    logic [4*ACC_W-1:0]       mem_data_q [OUT_DEPTH];
    logic [4*ACC_W-1:0]       mem_data_d [OUT_DEPTH];
    logic                     mem_mode_q [OUT_DEPTH];
    logic                     mem_mode_d [OUT_DEPTH];
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;

`ifdef ACC_SAT_EN
    logic [3:0]               sat_q, sat_d;
    logic [3:0]               mem_sat_q [OUT_DEPTH];
    logic [3:0]               mem_sat_d [OUT_DEPTH];
    logic [ACC_W:0]           wide_v [4];
    logic [3:0]               lane_sat;
    logic [3:0]               grp_sat;
`endif

    // ------------------------------------------------------------------
    // Lane extraction and per-lane add
    // ------------------------------------------------------------------
    logic                     eff_mode;
    logic signed [ACC_W-1:0]  lane_v [4];
    logic signed [ACC_W-1:0]  base_v [4];
    logic signed [ACC_W-1:0]  sum_v  [4];
    logic [4*ACC_W-1:0]       push_data;

    // Inside a group the first beat's mode decides the lane format, even if
    // the incoming mode disagrees (that case only raises mode_err).
    always_comb begin
        eff_mode = (state_q == S_ACCUM) ? grp_mode_q : mode;
        for (int k = 0; k < 4; k++) begin
            lane_v[k] = '0;
        end
        if (eff_mode) begin
            for (int k = 0; k < 4; k++) begin
                lane_v[k] = ACC_W'($signed(p[8*k +: 8]));
            end
        end else begin
            lane_v[0] = ACC_W'($signed(p[15:0]));
            lane_v[1] = ACC_W'($signed(p[31:16]));
        end
    end

    // A beat in IDLE starts a new group, so it adds onto zero rather than
    // whatever the previous group left in acc_q.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            base_v[k] = (state_q == S_ACCUM) ? acc_q[k] : '0;
        end
`ifdef ACC_SAT_EN
        for (int k = 0; k < 4; k++) begin
            wide_v[k]   = {base_v[k][ACC_W-1], base_v[k]} + {lane_v[k][ACC_W-1], lane_v[k]};
            lane_sat[k] = (wide_v[k][ACC_W] != wide_v[k][ACC_W-1]);
            if (lane_sat[k]) begin
                sum_v[k] = wide_v[k][ACC_W] ? SAT_MIN : SAT_MAX;
            end else begin
                sum_v[k] = wide_v[k][ACC_W-1:0];
            end
        end
        grp_sat = ((state_q == S_ACCUM) ? sat_q : 4'b0000) | lane_sat;
`else
        for (int k = 0; k < 4; k++) begin
            sum_v[k] = base_v[k] + lane_v[k];
        end
`endif
    end

    always_comb begin
        push_data = '0;
        for (int k = 0; k < 4; k++) begin
            push_data[k*ACC_W +: ACC_W] = sum_v[k];
        end
    end

    // ------------------------------------------------------------------
    // Group FSM
    // ------------------------------------------------------------------
    logic push_req;
    logic mode_set;

    always_comb begin
        state_d    = state_q;
        grp_mode_d = grp_mode_q;
        acc_d      = acc_q;
        push_req   = 1'b0;
        mode_set   = 1'b0;
`ifdef ACC_SAT_EN
        sat_d      = sat_q;
`endif
        if (p_valid) begin
            for (int k = 0; k < 4; k++) begin
                acc_d[k] = sum_v[k];
            end
`ifdef ACC_SAT_EN
            sat_d = grp_sat;
`endif
            if (state_q == S_IDLE) begin
                grp_mode_d = mode;
            end else if (mode != grp_mode_q) begin
                mode_set = 1'b1;
            end
            // The pushed value is sum_v, the sum including this final beat.
            if (p_last) begin
                push_req = 1'b1;
                state_d  = S_IDLE;
            end else begin
                state_d  = S_ACCUM;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic fifo_full;
    logic pop;
    logic push_ok;
    logic ovf_set;

    // A pop frees the slot the push writes into, so full+push+pop is legal:
    // head is read from mem_*_q before the edge that overwrites it.
    always_comb begin
        fifo_full = (count_q == DEPTH_C);
        pop       = (count_q != '0) && out_ready;
        push_ok   = push_req && (!fifo_full || pop);
        ovf_set   = push_req && fifo_full && !pop;

        wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        mem_data_d = mem_data_q;
        mem_mode_d = mem_mode_q;
`ifdef ACC_SAT_EN
        mem_sat_d  = mem_sat_q;
`endif
        if (push_ok) begin
            mem_data_d[wr_ptr_q] = push_data;
            mem_mode_d[wr_ptr_q] = grp_mode_d;
`ifdef ACC_SAT_EN
            mem_sat_d[wr_ptr_q]  = grp_sat;
`endif
        end
    end

    // Clear wins over a same-cycle set.
    always_comb begin
        ovf_err_d  = clr_err ? 1'b0 : (ovf_err_q  | ovf_set);
        mode_err_d = clr_err ? 1'b0 : (mode_err_q | mode_set);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            grp_mode_q <= 1'b0;
            ovf_err_q  <= 1'b0;
            mode_err_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int k = 0; k < 4; k++) begin
                acc_q[k] <= '0;
            end
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_mode_q[i] <= 1'b0;
            end
`ifdef ACC_SAT_EN
            sat_q <= 4'b0000;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_sat_q[i] <= 4'b0000;
            end
`endif
        end else begin
            state_q    <= state_d;
            grp_mode_q <= grp_mode_d;
            ovf_err_q  <= ovf_err_d;
            mode_err_q <= mode_err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            mem_data_q <= mem_data_d;
            mem_mode_q <= mem_mode_d;
`ifdef ACC_SAT_EN
            sat_q      <= sat_d;
            mem_sat_q  <= mem_sat_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs (head data forced to 0 while the FIFO is empty)
    // ------------------------------------------------------------------
    always_comb begin
        out_valid   = (count_q != '0);
        acc_out     = out_valid ? mem_data_q[rd_ptr_q] : '0;
        acc_mode    = out_valid ? mem_mode_q[rd_ptr_q] : 1'b0;
        almost_full = (count_q >= AF_C);
        ovf_err     = ovf_err_q;
        mode_err    = mode_err_q;
`ifdef ACC_SAT_EN
        sat_flag    = out_valid ? mem_sat_q[rd_ptr_q] : 4'b0000;
`endif
    end

endmodule

// File: tb/tb_arith_accumulator.sv
// tb/tb_arith_accumulator.sv - randomized self-checking bench for arith_accumulator
module tb_arith_accumulator;

    localparam int ACC_W     = 16;
    localparam int OUT_DEPTH = 4;
    localparam int SLACK     = 4;
    localparam int AF_TH     = ((OUT_DEPTH - SLACK) < 1) ? 1 : (OUT_DEPTH - SLACK);
    localparam longint LMAX  = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint LMIN  = -(longint'(1) <<< (ACC_W - 1));
    localparam longint MODV  = longint'(1) <<< ACC_W;

    logic                clk = 1'b0;
    logic                reset;
    logic [31:0]         p;
    logic                p_valid;
    logic                p_last;
    logic                mode;
    logic [4*ACC_W-1:0]  acc_out;
    logic                acc_mode;
    logic                out_valid;
    logic                out_ready;
    logic                almost_full;
    logic                ovf_err;
    logic                mode_err;
    logic                clr_err;
`ifdef ACC_SAT_EN
    logic [3:0]          sat_flag;
`endif

    always #5 clk = ~clk;

    arith_accumulator #(
        .ACC_W     (ACC_W),
        .OUT_DEPTH (OUT_DEPTH),
        .SLACK     (SLACK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .p           (p),
        .p_valid     (p_valid),
        .p_last      (p_last),
        .mode        (mode),
        .acc_out     (acc_out),
        .acc_mode    (acc_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .almost_full (almost_full),
        .ovf_err     (ovf_err),
        .mode_err    (mode_err),
`ifdef ACC_SAT_EN
        .sat_flag    (sat_flag),
`endif
        .clr_err     (clr_err)
    );

    // Reference model: a queue of finished group results plus the open group.
    typedef struct packed {
        logic                    md;
        logic [3:0]              sat;
        logic [3:0][ACC_W-1:0]   ln;
    } res_t;

    res_t    m_q[$];
    bit      m_active;
    bit      m_gmode;
    longint  m_acc [4];
    bit [3:0] m_sat;
    bit      m_ovf;
    bit      m_merr;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [ACC_W-1:0] lv(input longint v);
        return v[ACC_W-1:0];
    endfunction

    function automatic longint lane_of(input logic [31:0] w, input bit m, input int k);
        logic [7:0]  b;
        logic [15:0] h;
        if (m) begin
            b = w[8*k +: 8];
            return longint'($signed(b));
        end
        if (k < 2) begin
            h = w[16*k +: 16];
            return longint'($signed(h));
        end
        return 0;
    endfunction

    function automatic longint wrap(input longint s);
        longint r;
        r = s % MODV;
        if (r < 0) r += MODV;
        if (r > LMAX) r -= MODV;
        return r;
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("acc_out", acc_out, m_q[0].ln);
            chk("acc_mode", acc_mode, m_q[0].md);
`ifdef ACC_SAT_EN
            chk("sat_flag", sat_flag, m_q[0].sat);
`endif
        end else begin
            chk("acc_out_empty", acc_out, 0);
        end
        chk("almost_full", almost_full, m_q.size() >= AF_TH);
        chk("ovf_err", ovf_err, m_ovf);
        chk("mode_err", mode_err, m_merr);
    endtask

    task automatic step(input bit pv, input bit pl, input bit md, input logic [31:0] pw,
                        input bit rdy, input bit clr);
        bit     em;
        longint nv;
        res_t   e;
        p_valid   = pv;
        p_last    = pl;
        mode      = md;
        p         = pw;
        out_ready = rdy;
        clr_err   = clr;
        if (rdy && m_q.size() > 0) m_q.delete(0);
        if (pv) begin
            if (m_active && (md != m_gmode)) m_merr = 1'b1;
            if (!m_active) begin
                m_gmode = md;
                m_sat   = 4'b0000;
                for (int k = 0; k < 4; k++) m_acc[k] = 0;
            end
            em = m_gmode;
            for (int k = 0; k < 4; k++) begin
                nv = m_acc[k] + lane_of(pw, em, k);
`ifdef ACC_SAT_EN
                if (nv > LMAX) begin nv = LMAX; m_sat[k] = 1'b1; end
                else if (nv < LMIN) begin nv = LMIN; m_sat[k] = 1'b1; end
`else
                nv = wrap(nv);
`endif
                m_acc[k] = nv;
            end
            if (pl) begin
                e.md  = m_gmode;
                e.sat = m_sat;
                for (int k = 0; k < 4; k++) e.ln[k] = lv(m_acc[k]);
                if (m_q.size() < OUT_DEPTH) m_q.push_back(e);
                else m_ovf = 1'b1;
                m_active = 1'b0;
            end else begin
                m_active = 1'b1;
            end
        end
        if (clr) begin
            m_ovf  = 1'b0;
            m_merr = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        p_valid   = 1'b0;
        p_last    = 1'b0;
        mode      = 1'b0;
        p         = '0;
        out_ready = 1'b0;
        clr_err   = 1'b0;
        #3;
        m_q.delete();
        m_active = 1'b0;
        m_ovf    = 1'b0;
        m_merr   = 1'b0;
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        bit cur_mode;
        bit pv, pl, md;
        do_reset();

        // T1: three mode-1 beats
        step(1, 0, 1, 32'h01FF_7F80, 1, 0);
        step(1, 0, 1, 32'h01FF_7F80, 1, 0);
        chk("t1_not_yet", out_valid, 1'b0);
        step(1, 1, 1, 32'h01FF_7F80, 1, 0);
        chk("t1_l0", acc_out[0*ACC_W +: ACC_W], lv(-384));
        chk("t1_l1", acc_out[1*ACC_W +: ACC_W], lv(381));
        chk("t1_l2", acc_out[2*ACC_W +: ACC_W], lv(-3));
        chk("t1_l3", acc_out[3*ACC_W +: ACC_W], lv(3));
        chk("t1_mode", acc_mode, 1'b1);
        step(0, 0, 0, 32'h0, 1, 0);

        // T2: single-beat mode-0 group
        step(1, 1, 0, 32'h8000_7FFF, 1, 0);
        chk("t2_l0", acc_out[0*ACC_W +: ACC_W], lv(32767));
        chk("t2_l1", acc_out[1*ACC_W +: ACC_W], lv(-32768));
        chk("t2_l23", acc_out[2*ACC_W +: 2*ACC_W], 0);
        step(0, 0, 0, 32'h0, 1, 0);

        // T3: fill with out_ready low, fifth result is dropped
        for (int i = 0; i < 4; i++) step(1, 1, 1'($urandom_range(0, 1)), $urandom, 0, 0);
        step(1, 1, 0, $urandom, 0, 0);
        chk("t3_ovf", ovf_err, 1'b1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 32'h0, 1, (i == 4));

        // T4: full FIFO, push and pop in the same cycle
        for (int i = 0; i < 4; i++) step(1, 1, 1'($urandom_range(0, 1)), $urandom, 0, 0);
        step(1, 1, 1, $urandom, 1, 0);
        chk("t4_no_ovf", ovf_err, 1'b0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 32'h0, 1, 0);

        // T5: mode change inside a group, then clear
        step(1, 0, 0, 32'h0003_0005, 1, 0);
        step(1, 1, 1, 32'h0102_0304, 1, 0);
        chk("t5_merr", mode_err, 1'b1);
        step(0, 0, 0, 32'h0, 1, 1);
        chk("t5_clr", mode_err, 1'b0);

        // T6: lane-0 overflow
        step(1, 0, 0, 32'h0000_7FFF, 1, 0);
        step(1, 1, 0, 32'h0000_7FFF, 1, 0);
`ifdef ACC_SAT_EN
        chk("t6_l0_sat", acc_out[0 +: ACC_W], lv(32767));
        chk("t6_flag", sat_flag[0], 1'b1);
`else
        chk("t6_l0_wrap", acc_out[0 +: ACC_W], lv(-2));
`endif
        step(0, 0, 0, 32'h0, 1, 0);

        // Reset mid-group discards the partial sum
        step(1, 0, 1, 32'h7F7F_7F7F, 1, 0);
        do_reset();
        step(1, 1, 1, 32'h0101_0101, 1, 0);
        chk("rst_l0", acc_out[0 +: ACC_W], lv(1));
        chk("rst_l3", acc_out[3*ACC_W +: ACC_W], lv(1));

        // Randomized traffic
        cur_mode = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) do_reset();
            pv = ($urandom_range(0, 3) != 0);
            pl = ($urandom_range(0, 2) == 0);
            if (!m_active) cur_mode = 1'($urandom_range(0, 1));
            md = ($urandom_range(0, 15) == 0) ? !cur_mode : cur_mode;
            step(pv, pl, md, $urandom, ($urandom_range(0, 9) < 6), ($urandom_range(0, 31) == 0));
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 32'h0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
